load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 43 ++++
 rtl/load_store_unit_if.sv | 47 ++++
 rtl/load_store_unit_load_extend.sv | 32 +++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared ISA definitions for the core: datapath width, load/store operation
// encodings carried on req_op, and the load/store unit state encoding.
// Small helpers classify operations so every user agrees on the rules.
package load_store_unit_pkg;

  // Architectural data width (registers and data bus).
  localparam int XLEN = 32;

  // Load/store operation encodings carried on req_op.
  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  // Load/store unit control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic is_load(lsu_op_e op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(lsu_op_e op, logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      OP_LW, OP_SW:         return addr_lo != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle between the CPU, the load/store unit and the word-wide data memory.
//   CPU side   : req_valid/req_ready, req_op, req_addr, req_wdata,
//                resp_valid, resp_rdata, resp_fault
//   Memory side: mem_en, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//   Debug      : dbg_state (current control state of the unit)
// Handshake semantics: a request transfers on a rising clock edge where
// req_valid && req_ready are both 1; op/addr/wdata are taken at that edge.
// resp_valid is a one-cycle completion pulse with no back-pressure. A memory
// access is requested while mem_en is 1 and completes on the edge where
// mem_ack is 1; mem_ack is meaningless while mem_en is 0.
// Modport slave is the load/store unit; master is its environment.
interface load_store_unit_if #(
  parameter int MEM_WORDS = 1024
);
  import load_store_unit_pkg::*;

  localparam int AW = $clog2(MEM_WORDS);

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;
  lsu_state_e      dbg_state;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_state
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_state
  );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// load_extend: selects the byte or halfword lane addressed by addr_i within a
// little-endian word and sign- or zero-extends it according to op_i.
//   op_i     : load operation (LB/LBU/LH/LHU/LW; other codes pass the word)
//   addr_i   : low two byte-address bits
//   word_i   : full memory word
//   result_o : extended lane
module load_extend
  import load_store_unit_pkg::*;
(
  input  lsu_op_e     op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    result_o = word_i;
    case (op_i)
      OP_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result_o = {24'h0, byte_sel};
      OP_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result_o = {16'h0, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns CPU byte/halfword/word loads and stores into accesses
// on a word-wide data memory. Sub-word stores are read-modify-write.
//   clock   : rising-edge system clock
//   reset_n : asynchronous active-low reset; abandons any access in flight
//   bus     : load_store_unit_if.slave (CPU request/response, memory port,
//             debug state)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input logic              clock,
  input logic              reset_n,
  load_store_unit_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);

  lsu_state_e  state_q, state_d;
  lsu_op_e     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        fault_q, fault_d;

  lsu_op_e     req_op;
  lsu_op_e     ext_op;
  logic [31:0] lane_val;
  logic [31:0] new_lane;
  logic [31:0] merged;
  logic [4:0]  lane_shift;

  // Byte address bits above the memory size only alias; they are not decoded.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:AW+2];

  assign req_op        = lsu_op_e'(bus.req_op);
  assign bus.dbg_state = state_q;

  // The extender serves both paths: it produces load results, and for
  // SB/SH it extracts the old lane (zero-extended) so the merge can swap it.
  always_comb begin
    ext_op = op_q;
    if (op_q == OP_SB)      ext_op = OP_LBU;
    else if (op_q == OP_SH) ext_op = OP_LHU;
  end

  load_extend u_load_extend (
    .op_i     (ext_op),
    .addr_i   (addr_q[1:0]),
    .word_i   (word_q),
    .result_o (lane_val)
  );

  // XOR out the old lane and XOR in the new one; other bytes are untouched.
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    new_lane   = (op_q == OP_SB) ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q[15:0]};
    merged     = word_q ^ ((lane_val ^ new_lane) << lane_shift);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    word_d         = word_q;
    fault_d        = fault_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_fault = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = req_op;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          fault_d = is_misaligned(req_op, bus.req_addr[1:0]);
          if (fault_d)                state_d = ST_RESP;
          else if (req_op == OP_SW)   state_d = ST_WRITE;
          else                        state_d = ST_READ;
        end
      end

      ST_READ: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = addr_q[AW+1:2];
        if (bus.mem_ack) begin
          word_d  = bus.mem_rdata;
          state_d = is_load(op_q) ? ST_RESP : ST_WRITE;
        end
      end

      ST_WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q[AW+1:2];
        bus.mem_wdata = (op_q == OP_SW) ? wdata_q : merged;
        if (bus.mem_ack) state_d = ST_RESP;
      end

      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_fault = fault_q;
        if (!fault_q && is_load(op_q)) bus.resp_rdata = lane_val;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios followed by random
// operations against a byte-addressed reference memory.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int AW        = $clog2(MEM_WORDS);
  localparam int MEM_BYTES = 4 * MEM_WORDS;
  localparam int TIMEOUT   = 100;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  load_store_unit_if #(.MEM_WORDS(MEM_WORDS)) bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  // reference memory, one entry per byte address
  logic [7:0]  ref_bytes [MEM_BYTES];

  // ---------------- memory responder + monitor ----------------
  logic [31:0]   mem_words [MEM_WORDS];
  logic          mem_load      = 1'b0;
  int            ack_delay     = 0;   // 0: mem_ack tied high
  int            ack_cnt       = 0;
  int            en_cycles     = 0;
  int            rd_acks       = 0;
  int            wr_acks       = 0;
  int            addr_errs     = 0;
  int            wdata_changes = 0;
  logic [AW-1:0] exp_waddr     = '0;
  logic          prev_wr_wait  = 1'b0;
  logic [31:0]   prev_wdata    = '0;

  assign bus.mem_rdata = mem_words[bus.mem_addr];

  always_comb
    bus.mem_ack = (ack_delay == 0) ? 1'b1 : (bus.mem_en && (ack_cnt == ack_delay - 1));

  always @(posedge clock) begin
    if (mem_load) begin
      for (int w = 0; w < MEM_WORDS; w++)
        mem_words[w] = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    end else if (bus.mem_en && bus.mem_we && bus.mem_ack) begin
      mem_words[bus.mem_addr] = bus.mem_wdata;
    end
    if (bus.mem_en) begin
      en_cycles++;
      if (bus.mem_addr !== exp_waddr) addr_errs++;
      if (bus.mem_ack) begin
        if (bus.mem_we) wr_acks++;
        else            rd_acks++;
      end
    end
    if (prev_wr_wait && bus.mem_en && bus.mem_we && (bus.mem_wdata !== prev_wdata))
      wdata_changes++;
    prev_wr_wait <= bus.mem_en && bus.mem_we && !bus.mem_ack;
    prev_wdata   <= bus.mem_wdata;
    ack_cnt      <= (!bus.mem_en || bus.mem_ack) ? 0 : ack_cnt + 1;
  end

  // ---------------- reference model ----------------
  function automatic int op_size(logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic logic op_is_store(logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [31:0] ref_word(int a);
    return {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] op, int a);
    int v;
    v = 0;
    case (op)
      OP_LB:  begin v = int'(ref_bytes[a]); if (v > 127) v -= 256; end
      OP_LBU: v = int'(ref_bytes[a]);
      OP_LH:  begin v = int'(ref_bytes[a]) + 256 * int'(ref_bytes[a+1]); if (v > 32767) v -= 65536; end
      OP_LHU: v = int'(ref_bytes[a]) + 256 * int'(ref_bytes[a+1]);
      default: v = int'(ref_bytes[a]) | (int'(ref_bytes[a+1]) << 8) |
                   (int'(ref_bytes[a+2]) << 16) | (int'(ref_bytes[a+3]) << 24);
    endcase
    return 32'(v);
  endfunction

  function automatic void ref_store(logic [2:0] op, int a, logic [31:0] wdata);
    for (int k = 0; k < op_size(op); k++) ref_bytes[a+k] = 8'(wdata >> (8 * k));
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one request, checked end to end ----------------
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input string name,
                        output logic [31:0] got_rdata);
    int          size, r, lat, exp_lat, exp_en, exp_rd, exp_wr, busy_ready;
    int          en0, rd0, wr0, ae0, wc0, a;
    logic        exp_fault, seen, got_fault, got_ready;
    logic [31:0] exp_rdata;
    a         = int'(addr);
    size      = op_size(op);
    exp_fault = (a % size) != 0;
    r         = (ack_delay == 0) ? 1 : ack_delay;
    exp_rdata = '0;
    if (exp_fault) begin
      exp_lat = 1; exp_en = 0; exp_rd = 0; exp_wr = 0;
    end else if (!op_is_store(op)) begin
      exp_lat = r + 1; exp_en = r; exp_rd = 1; exp_wr = 0;
      exp_rdata = ref_load(op, a);
    end else if (op == OP_SW) begin
      exp_lat = r + 1; exp_en = r; exp_rd = 0; exp_wr = 1;
    end else begin
      exp_lat = 2 * r + 1; exp_en = 2 * r; exp_rd = 1; exp_wr = 1;
    end
    exp_q.push_back(exp_rdata);
    exp_waddr = addr[AW+1:2];

    @(negedge clock);
    check({name, "_ready_idle"}, bus.req_ready, 1);
    en0 = en_cycles; rd0 = rd_acks; wr0 = wr_acks; ae0 = addr_errs; wc0 = wdata_changes;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clock);

    lat = 0; seen = 1'b0; busy_ready = 0;
    got_rdata = '0; got_fault = 1'b0; got_ready = 1'b0;
    while (!seen && lat < TIMEOUT) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        // scramble the request lines so a late re-sample would be visible
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
      end
      if (bus.resp_valid) begin
        seen      = 1'b1;
        got_rdata = bus.resp_rdata;
        got_fault = bus.resp_fault;
        got_ready = bus.req_ready;
      end else if (bus.req_ready) begin
        busy_ready++;
      end
    end

    check({name, "_resp_seen"}, seen, 1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_fault"}, got_fault, exp_fault);
    check({name, "_rdata"}, got_rdata, exp_q.pop_front());
    check({name, "_ready_in_resp"}, got_ready, 0);
    check({name, "_ready_busy"}, busy_ready, 0);
    check({name, "_en_cycles"}, en_cycles - en0, exp_en);
    check({name, "_reads"}, rd_acks - rd0, exp_rd);
    check({name, "_writes"}, wr_acks - wr0, exp_wr);
    check({name, "_mem_addr"}, addr_errs - ae0, 0);
    check({name, "_wdata_stable"}, wdata_changes - wc0, 0);

    if (op_is_store(op) && !exp_fault) begin
      ref_store(op, a, wdata);
      check({name, "_mem_word"}, mem_words[a / 4], ref_word(a - (a % 4)));
    end

    @(negedge clock);
    check({name, "_single_pulse"}, bus.resp_valid, 0);
    check({name, "_ready_after"}, bus.req_ready, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] got;
    int          waited, resp_cnt, wr0, diffs;

    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    for (int i = 0; i < MEM_BYTES; i++) ref_bytes[i] = 8'($urandom);
    // word at byte address 0x100 = 0x00008090
    ref_bytes[32'h100] = 8'h90; ref_bytes[32'h101] = 8'h80;
    ref_bytes[32'h102] = 8'h00; ref_bytes[32'h103] = 8'h00;
    mem_load = 1'b1;

    // reset values while held in reset
    repeat (3) @(negedge clock);
    check("rst_req_ready",  bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_fault", bus.resp_fault, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_en",     bus.mem_en, 0);
    check("rst_mem_we",     bus.mem_we, 0);
    check("rst_mem_addr",   bus.mem_addr, 0);
    check("rst_mem_wdata",  bus.mem_wdata, 0);
    check("rst_dbg_state",  bus.dbg_state, ST_IDLE);
    mem_load = 1'b0;
    reset_n  = 1'b1;
    @(negedge clock);
    check("post_rst_ready",  bus.req_ready, 1);
    check("post_rst_mem_en", bus.mem_en, 0);

    // sign/zero extension on the known word
    run_op(OP_LH,  32'h100, 32'h0, "lh_100", got);   check("lh_100_const",  got, 32'hffff8090);
    run_op(OP_LHU, 32'h100, 32'h0, "lhu_100", got);  check("lhu_100_const", got, 32'h00008090);
    run_op(OP_LB,  32'h101, 32'h0, "lb_101", got);   check("lb_101_const",  got, 32'hffffff80);
    run_op(OP_LBU, 32'h100, 32'h0, "lbu_100", got);  check("lbu_100_const", got, 32'h00000090);
    run_op(OP_LW,  32'h100, 32'h0, "lw_100", got);   check("lw_100_const",  got, 32'h00008090);

    // read-modify-write byte store
    run_op(OP_SB, 32'h102, 32'h123456ff, "sb_102", got);
    check("sb_102_word_const", mem_words[32'h100 / 4], 32'h00ff8090);
    check("sb_102_rdata_zero", got, 0);

    // misaligned accesses
    run_op(OP_SH, 32'h101, 32'hcafe, "sh_101_fault", got);
    run_op(OP_LW, 32'h102, 32'h0,    "lw_102_fault", got);

    // slow memory: ack on the fourth enabled cycle
    ack_delay = 4;
    run_op(OP_LW, 32'h100, 32'h0, "lw_slow", got);
    check("lw_slow_const", got, 32'h00ff8090);

    // reset while a halfword store waits in its write phase
    ack_delay = 3;
    exp_waddr = AW'(32'h104 >> 2);
    wr0 = wr_acks;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SH;
    bus.req_addr  = 32'h104;
    bus.req_wdata = 32'h0000beef;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    waited = 0;
    while (!(bus.mem_en && bus.mem_we) && waited < TIMEOUT) begin
      @(negedge clock);
      waited++;
    end
    check("rst_mid_reached_write", bus.mem_we, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_async_ready",  bus.req_ready, 1);
    check("rst_mid_async_mem_en", bus.mem_en, 0);
    check("rst_mid_async_resp",   bus.resp_valid, 0);
    repeat (2) @(negedge clock);
    reset_n  = 1'b1;
    resp_cnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.resp_valid) resp_cnt++;
    end
    check("rst_mid_no_resp",  resp_cnt, 0);
    check("rst_mid_ready",    bus.req_ready, 1);
    check("rst_mid_no_write", wr_acks - wr0, 0);
    check("rst_mid_mem_word", mem_words[32'h104 / 4], ref_word(32'h104));
    ack_delay = 0;
    run_op(OP_LW, 32'h104, 32'h0, "lw_after_rst", got);

    // random operations, mostly aligned, with varying memory latency
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      int          sz;
      ack_delay = $urandom_range(0, 3);
      op        = 3'($urandom_range(0, 7));
      sz        = op_size(op);
      a         = $urandom_range(0, MEM_BYTES - 1);
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      run_op(op, a, $urandom, "rand", got);
    end

    // whole memory image against the reference
    diffs = 0;
    for (int w = 0; w < MEM_WORDS; w++)
      if (mem_words[w] !== ref_word(4 * w)) diffs++;
    check("final_mem_image", diffs, 0);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
